// File: rtl/te_block_decoder.sv
// Trace block decoder: expands one compressed retirement block into a
// per-instruction PC stream, using a consumer-supplied size lookup.
package mure_pkg;
    parameter int XLEN        = 32;
    parameter int IRETIRE_LEN = 14;
    parameter int ITYPE_LEN   = 3;
    parameter int CAUSE_LEN   = 5;
    parameter int PRIV_LEN    = 2;
endpackage

module te_block_decoder
    import mure_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [XLEN-1:0]        iaddr_i,
    input  logic [IRETIRE_LEN-1:0] iretire_i,
    input  logic                   ilastsize_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic [CAUSE_LEN-1:0]   cause_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic                   compressed_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [XLEN-1:0]        pc_o,
    output logic                   compressed_o,
    output logic                   last_o,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [CAUSE_LEN-1:0]   cause_o,
    output logic [XLEN-1:0]        tval_o,
    output logic [PRIV_LEN-1:0]    priv_o,
    output logic                   err_o
);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic [IRETIRE_LEN-1:0] rem_q, rem_d;
    logic                   ilastsize_q, ilastsize_d;
    logic [ITYPE_LEN-1:0]   itype_q, itype_d;
    logic [CAUSE_LEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]        tval_q, tval_d;
    logic [PRIV_LEN-1:0]    priv_q, priv_d;
    logic                   err_q, err_d;

    logic [IRETIRE_LEN-1:0] size;
    logic                   is_last;
    logic                   overrun;
    logic                   mismatch;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            rem_q       <= '0;
            ilastsize_q <= 1'b0;
            itype_q     <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            priv_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rem_q       <= rem_d;
            ilastsize_q <= ilastsize_d;
            itype_q     <= itype_d;
            cause_q     <= cause_d;
            tval_q      <= tval_d;
            priv_q      <= priv_d;
            err_q       <= err_d;
        end
    end

    // Size in halfwords of the instruction currently at pc_q.
    assign size     = compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
    assign overrun  = (rem_q == IRETIRE_LEN'(1)) && !compressed_i;
    assign mismatch = (rem_q == size) && (ilastsize_q == compressed_i);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rem_d       = rem_q;
        ilastsize_d = ilastsize_q;
        itype_d     = itype_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        priv_d      = priv_q;
        err_d       = 1'b0;
        blk_ready_o = 1'b0;
        valid_o     = 1'b0;
        is_last     = 1'b0;

        case (state_q)
            IDLE: begin
                blk_ready_o = 1'b1;
                if (blk_valid_i) begin
                    if (iretire_i != '0) begin
                        pc_d        = iaddr_i;
                        rem_d       = iretire_i;
                        ilastsize_d = ilastsize_i;
                        itype_d     = itype_i;
                        cause_d     = cause_i;
                        tval_d      = tval_i;
                        priv_d      = priv_i;
                        state_d     = EXPAND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXPAND: begin
                valid_o = 1'b1;
                is_last = (rem_q <= size);
                if (ready_i) begin
                    err_d = overrun || mismatch;
                    // The final beat leaves rem_q untouched so it never underflows.
                    if (is_last) begin
                        state_d = IDLE;
                    end else begin
                        pc_d  = pc_q + (compressed_i ? XLEN'(2) : XLEN'(4));
                        rem_d = rem_q - size;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_o         = valid_o ? pc_q : '0;
    assign compressed_o = valid_o && compressed_i;
    assign last_o       = is_last;
    assign itype_o      = is_last ? itype_q : '0;
    assign cause_o      = is_last ? cause_q : '0;
    assign tval_o       = is_last ? tval_q  : '0;
    assign priv_o       = is_last ? priv_q  : '0;
    assign err_o        = err_q;

endmodule

// File: tb/tb_te_block_decoder.sv
// Self-checking bench for te_block_decoder: directed plan cases plus
// random well-formed blocks built from instruction-size lists.
module tb_te_block_decoder;
    import mure_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   blk_valid_i = 1'b0;
    logic                   blk_ready_o;
    logic [XLEN-1:0]        iaddr_i = '0;
    logic [IRETIRE_LEN-1:0] iretire_i = '0;
    logic                   ilastsize_i = 1'b0;
    logic [ITYPE_LEN-1:0]   itype_i = '0;
    logic [CAUSE_LEN-1:0]   cause_i = '0;
    logic [XLEN-1:0]        tval_i = '0;
    logic [PRIV_LEN-1:0]    priv_i = '0;
    logic                   compressed_i = 1'b0;
    logic                   valid_o;
    logic                   ready_i = 1'b0;
    logic [XLEN-1:0]        pc_o;
    logic                   compressed_o;
    logic                   last_o;
    logic [ITYPE_LEN-1:0]   itype_o;
    logic [CAUSE_LEN-1:0]   cause_o;
    logic [XLEN-1:0]        tval_o;
    logic [PRIV_LEN-1:0]    priv_o;
    logic                   err_o;

    int errors = 0;
    int checks = 0;
    // Instruction image of the block under test: 1 = 32-bit, 0 = 16-bit.
    bit is32_q[$];

    always #5 clk_i = ~clk_i;

    te_block_decoder dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
        .iaddr_i(iaddr_i), .iretire_i(iretire_i), .ilastsize_i(ilastsize_i),
        .itype_i(itype_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
        .compressed_i(compressed_i), .valid_o(valid_o), .ready_i(ready_i),
        .pc_o(pc_o), .compressed_o(compressed_o), .last_o(last_o),
        .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
        .err_o(err_o)
    );

    // Offers one block and walks the expected entries. Expected PCs are the
    // running sum of instruction sizes; side fields appear only on the last.
    task automatic run_block(input logic [XLEN-1:0] addr, input logic [IRETIRE_LEN-1:0] iret,
                             input logic ils, input logic [ITYPE_LEN-1:0] ity,
                             input logic [CAUSE_LEN-1:0] cs, input logic [XLEN-1:0] tv,
                             input logic [PRIV_LEN-1:0] pv, input int n_exp, input bit err_exp,
                             input int stall_beat, input int stall_n, input bit rnd_stall,
                             output int hs);
        logic [XLEN-1:0] pc_exp;
        bit              lst;
        int              waitc;
        int              nst;
        hs = 0;
        waitc = 0;
        while (!blk_ready_o && waitc < 50) begin
            @(posedge clk_i); #1;
            waitc++;
        end
        checks++;
        if (blk_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL blk_ready_timeout: got %b want 1", blk_ready_o);
        end
        blk_valid_i = 1'b1;
        iaddr_i = addr; iretire_i = iret; ilastsize_i = ils;
        itype_i = ity; cause_i = cs; tval_i = tv; priv_i = pv;
        @(posedge clk_i); #1;
        blk_valid_i = 1'b0;
        iaddr_i = '0; itype_i = '0; cause_i = '0; tval_i = '0; priv_i = '0;
        if (n_exp == 0) begin
            checks++;
            if (valid_o !== 1'b0 || err_o !== err_exp || blk_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL empty_block: valid=%b err=%b rdy=%b want 0 %b 1", valid_o, err_o, blk_ready_o, err_exp);
            end
            @(posedge clk_i); #1;
            checks++;
            if (err_o !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse_width: got %b want 0", err_o);
            end
            return;
        end
        pc_exp = addr;
        for (int i = 0; i < n_exp; i++) begin
            lst = (i == n_exp - 1);
            compressed_i = !is32_q[i];
            nst = (i == stall_beat) ? stall_n : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= nst; s++) begin
                ready_i = (s == nst);
                #1;
                checks++;
                if (valid_o !== 1'b1 || pc_o !== pc_exp || last_o !== lst || compressed_o !== !is32_q[i]) begin
                    errors++;
                    $display("FAIL entry%0d: valid=%b pc=%h last=%b c=%b want 1 %h %b %b",
                             i, valid_o, pc_o, last_o, compressed_o, pc_exp, lst, !is32_q[i]);
                end
                checks++;
                if (itype_o !== (lst ? ity : '0) || cause_o !== (lst ? cs : '0) ||
                    tval_o !== (lst ? tv : '0) || priv_o !== (lst ? pv : '0) || blk_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL side%0d: it=%h c=%h tv=%h pv=%h rdy=%b", i, itype_o, cause_o, tval_o, priv_o, blk_ready_o);
                end
                if (ready_i) hs++;
                @(posedge clk_i); #1;
                if (!lst) begin
                    checks++;
                    if (err_o !== 1'b0) begin
                        errors++;
                        $display("FAIL err_midblock%0d: got %b want 0", i, err_o);
                    end
                end
            end
            pc_exp = pc_exp + (is32_q[i] ? XLEN'(4) : XLEN'(2));
        end
        ready_i = 1'b0;
        checks++;
        if (err_o !== err_exp || valid_o !== 1'b0 || blk_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL block_end: err=%b valid=%b rdy=%b want %b 0 1", err_o, valid_o, blk_ready_o, err_exp);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (blk_ready_o !== 1'b1 || valid_o !== 1'b0 || pc_o !== '0 || last_o !== 1'b0 ||
            err_o !== 1'b0 || compressed_o !== 1'b0 || itype_o !== '0 || tval_o !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b valid=%b pc=%h last=%b err=%b", blk_ready_o, valid_o, pc_o, last_o, err_o);
        end
    endtask

    task automatic test_all_compressed();
        int hs;
        is32_q = '{0, 0, 0};
        run_block(32'h1000, 14'd3, 1'b0, 3'd2, '0, '0, '0, 3, 1'b0, -1, 0, 1'b0, hs);
    endtask

    task automatic test_mixed();
        int hs;
        is32_q = '{0, 1, 1};
        run_block(32'h2000, 14'd5, 1'b1, 3'd0, '0, '0, '0, 3, 1'b0, -1, 0, 1'b0, hs);
    endtask

    task automatic test_backpressure();
        int hs;
        is32_q = '{0, 1, 1};
        run_block(32'h2000, 14'd5, 1'b1, 3'd0, '0, '0, '0, 3, 1'b0, 1, 3, 1'b0, hs);
        checks++;
        if (hs !== 3) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d want 3", hs);
        end
    endtask

    task automatic test_exception();
        int hs;
        is32_q = '{1};
        run_block(32'h3000, 14'd2, 1'b1, 3'd1, 5'd5, 32'hDEAD, 2'd3, 1, 1'b0, -1, 0, 1'b0, hs);
    endtask

    task automatic test_errors();
        int hs;
        is32_q.delete();
        run_block(32'h4000, 14'd0, 1'b0, 3'd0, '0, '0, '0, 0, 1'b1, -1, 0, 1'b0, hs);
        is32_q = '{1};
        run_block(32'h4100, 14'd1, 1'b0, 3'd3, 5'd1, 32'h1, 2'd1, 1, 1'b1, -1, 0, 1'b0, hs);
        is32_q = '{1};
        run_block(32'h4200, 14'd2, 1'b0, 3'd4, 5'd2, 32'h2, 2'd0, 1, 1'b1, -1, 0, 1'b0, hs);
    endtask

    task automatic test_wrap();
        int hs;
        is32_q = '{0, 0};
        run_block(32'hFFFF_FFFE, 14'd2, 1'b0, 3'd5, '0, '0, '0, 2, 1'b0, -1, 0, 1'b0, hs);
    endtask

    task automatic test_reset_midblock();
        blk_valid_i = 1'b1; iaddr_i = 32'h5000; iretire_i = 14'd4; ilastsize_i = 1'b0;
        @(posedge clk_i); #1;
        blk_valid_i = 1'b0;
        compressed_i = 1'b1; ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 32'h5002) begin
            errors++;
            $display("FAIL rst_second_entry: valid=%b pc=%h want 1 00005002", valid_o, pc_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || pc_o !== '0) begin
            errors++;
            $display("FAIL rst_async_drop: valid=%b pc=%h want 0 0", valid_o, pc_o);
        end
        ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (blk_ready_o !== 1'b1 || valid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: rdy=%b valid=%b err=%b want 1 0 0", blk_ready_o, valid_o, err_o);
        end
    endtask

    task automatic test_random_blocks();
        int hs;
        int n;
        int hw;
        for (int b = 0; b < 30; b++) begin
            n = int'($urandom_range(1, 6));
            is32_q.delete();
            hw = 0;
            for (int k = 0; k < n; k++) begin
                is32_q.push_back(bit'($urandom_range(0, 1)));
                hw += is32_q[k] ? 2 : 1;
            end
            run_block(XLEN'($urandom) & ~XLEN'(1), IRETIRE_LEN'(hw), is32_q[n-1],
                      ITYPE_LEN'($urandom), CAUSE_LEN'($urandom), XLEN'($urandom), PRIV_LEN'($urandom),
                      n, 1'b0, -1, 0, 1'b1, hs);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        test_all_compressed();
        test_mixed();
        test_backpressure();
        test_exception();
        test_errors();
        test_wrap();
        test_reset_midblock();
        test_random_blocks();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/te_block_decoder.md
# te_block_decoder

Reverse of the instruction-block compressor in the trace connector. It accepts one compressed retirement block (`iaddr`, `iretire`, `ilastsize`, `itype`, `cause`, `tval`, `priv`) and re-expands it into a per-instruction retirement stream: one PC per cycle under valid/ready. Instruction sizes come from a program-image lookup supplied by the consumer. It sits on the bench/decoder side of the trace path, where it checks encoder output against the original retirement stream.

## Interface
Parameters:
- None. All widths come from `mure_pkg`: `XLEN`, `IRETIRE_LEN`, `ITYPE_LEN`, `CAUSE_LEN`, `PRIV_LEN`.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `blk_valid_i` in 1: block present.
- `blk_ready_o` out 1: block accepted when `blk_valid_i && blk_ready_o`.
- `iaddr_i` in XLEN: byte PC of the first instruction in the block.
- `iretire_i` in IRETIRE_LEN: block length in halfwords.
- `ilastsize_i` in 1: last instruction is 32-bit (1) or 16-bit (0).
- `itype_i` in ITYPE_LEN: type of the block-ending instruction.
- `cause_i` in CAUSE_LEN, `tval_i` in XLEN, `priv_i` in PRIV_LEN: trap/priv info for the last instruction.
- `compressed_i` in 1: program-image lookup for the current `pc_o`; 1 means a 16-bit instruction. Sampled combinationally whenever `valid_o` is high.
- `valid_o` out 1: instruction entry present.
- `ready_i` in 1: consumer accepts the entry.
- `pc_o` out XLEN: instruction PC.
- `compressed_o` out 1: equals `compressed_i`.
- `last_o` out 1: final instruction of the block.
- `itype_o` out ITYPE_LEN: latched `itype` when `last_o`, else 0.
- `cause_o`, `tval_o`, `priv_o`: latched values when `last_o`, else 0.
- `err_o` out 1: registered one-cycle protocol-error pulse.

## Operation
- States: `IDLE`, `EXPAND` (local enum).
- Registers:
  - `pc_q` (XLEN)
  - `rem_q` (IRETIRE_LEN, halfwords remaining)
  - latched `ilastsize`, `itype`, `cause`, `tval`, `priv`
  - `err_q`
- IDLE:
  - `blk_ready_o`=1, `valid_o`=0.
  - On handshake with `iretire_i` != 0: `pc_q`←`iaddr_i`, `rem_q`←`iretire_i`, latch the side fields, go to EXPAND.
  - On handshake with `iretire_i`==0: discard the block, `err_q`←1, stay in IDLE.
- EXPAND:
  - `blk_ready_o`=0, `valid_o`=1, `pc_o`=`pc_q`.
  - size = `compressed_i` ? 1 : 2 halfwords.
  - `last_o` = (`rem_q` <= size).
- On `valid_o && ready_i` in EXPAND:
  - not last: `pc_q`←`pc_q` + 2·size, modulo 2^XLEN; `rem_q`←`rem_q` − size; stay in EXPAND.
  - last: go to IDLE.
  - `err_q`←1 if `rem_q`=1 and `compressed_i`=0 (overrun). The entry is still emitted as last with `compressed_o`=0.
  - `err_q`←1 if (`rem_q` == size) and `ilastsize_q` != !`compressed_i` (last-size mismatch).
- With `ready_i`=0 all registers hold. `pc_o`, `last_o` and side outputs stay stable. `compressed_o` follows `compressed_i`, and the lookup must be stable for a fixed `pc_o`.
- `err_q` is cleared every cycle in which no error condition occurs, so `err_o` is a single-cycle pulse.

## Timing
- Reset values:
  - state IDLE
  - `blk_ready_o`=1
  - `valid_o`=0, `last_o`=0, `err_o`=0
  - `pc_o`=0, `compressed_o`=0 (gated by `valid_o`)
  - `itype_o`, `cause_o`, `tval_o`, `priv_o` = 0
  - all registers 0
- Latency:
  - Block accepted at cycle N → first entry on `valid_o` at N+1.
  - A block of k instructions with a consumer always ready occupies cycles N+1..N+k.
  - Next `blk_ready_o` at N+k+1, giving one bubble between blocks.
- Error timing: `err_o` asserts the cycle after the offending handshake.
- Reset asserted mid-block: the block is dropped immediately (asynchronous). `valid_o` falls in the same cycle, with no partial-block recovery.
- `rem_q` never underflows: the last beat always moves to IDLE without a subtraction.

## Test plan
- All-compressed block: block `iaddr`=0x1000, `iretire`=3, `ilastsize`=0, `itype`=2, `compressed_i`=1 → PCs 0x1000, 0x1002, 0x1004; `last_o` only on 0x1004 with `itype_o`=2; `err_o`=0.
- Mixed sizes: block `iaddr`=0x2000, `iretire`=5, `ilastsize`=1; sizes 16/32/32 → PCs 0x2000, 0x2002, 0x2006; last on 0x2006; no error.
- Backpressure: previous block with `ready_i` low for 3 cycles on the second entry → `pc_o` held at 0x2002, then resumes; total of 3 handshakes.
- Single exception instruction: block `iretire`=2, `ilastsize`=1, `itype`=1, `cause`=5, `tval`=0xDEAD, `priv`=3, `compressed_i`=0 → one entry, `last_o`=1, side outputs carried through, `blk_ready_o` high 2 cycles after acceptance.
- Errors:
  - `iretire`=0 → no entries, `err_o` pulse next cycle.
  - `iretire`=1 with `compressed_i`=0 → one last entry plus an `err_o` pulse.
  - `iretire`=2, `ilastsize`=0, single 32-bit instruction → mismatch pulse.
- PC wrap and reset: `iaddr`=2^XLEN−2, `iretire`=2, all compressed → PCs 0xFF..FE, then 0x0. Separately, `rst_ni` low during the second entry → `valid_o`=0 immediately, `blk_ready_o`=1 after release.
